// File: rtl/pipeline_run_control_if.sv
// Command channel from the debug host to the pipeline run controller.
//
// Handshake: a command (cmd_op, cmd_count) transfers on a rising clk edge
// where cmd_valid and cmd_ready are both high. The master holds cmd_op and
// cmd_count stable while cmd_valid is high. The slave raises cmd_ready
// whenever it is out of reset.
//
// Signals:
//   cmd_valid  master -> slave  command strobe
//   cmd_ready  slave -> master  command acceptance
//   cmd_op     master -> slave  00 NOP, 01 RUN, 10 HALT, 11 STEP
//   cmd_count  master -> slave  enabled-cycle count for STEP
interface pipeline_run_control_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_count,
    output cmd_ready
  );
endinterface

// File: rtl/pipeline_run_control.sv
// Run/halt/step controller for the five-stage pipeline.
//
// Drives pipe_en, the single clock-enable for the PC and the IF_ID, ID_EX,
// EX_MEM and MEM_WB registers. A debug host can freeze, resume or single-step
// the datapath, and an instruction-address breakpoint on the IF-stage PC halts
// it before the matching instruction is latched into IF_ID.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   cmd          command channel (slave side): valid/ready/op/count
//   bp_en        breakpoint enable
//   bp_addr      breakpoint PC
//   pc_if        PC currently presented to instruction memory
//   pipe_en      clock-enable for PC and all pipeline registers
//   state        00 HALTED, 01 RUNNING, 10 STEPPING
//   done_pulse   one-cycle pulse: STEP completed or breakpoint halted
//   bp_hit       sticky: the last halt was caused by the breakpoint
//   cmd_err      one-cycle pulse: RUN/STEP issued while not HALTED
//   cycle_count  number of edges with pipe_en = 1 (wraps)
module pipeline_run_control #(
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  pipeline_run_control_if.slave         cmd,
  input  logic                          bp_en,
  input  logic [31:0]                   bp_addr,
  input  logic [31:0]                   pc_if,
  output logic                          pipe_en,
  output logic [1:0]                    state,
  output logic                          done_pulse,
  output logic                          bp_hit,
  output logic                          cmd_err,
  output logic [31:0]                   cycle_count
);

  typedef enum logic [1:0] {
    S_HALTED   = 2'b00,
    S_RUNNING  = 2'b01,
    S_STEPPING = 2'b10
  } state_t;

  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_STEP = 2'b11;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             skip_q, skip_d;
  logic             bp_hit_d;
  logic             done_d;
  logic             err_d;

  logic             accept;
  logic             acc_run, acc_halt, acc_step;
  logic             active;
  logic             bp_match;

  // Ready is tied to reset so it drops immediately when reset asserts.
  assign cmd.cmd_ready = rst_n;

  assign state = state_q;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HALTED;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Output / decode logic (combinational)
  // ---------------------------------------------------------------------
  always_comb begin
    accept   = cmd.cmd_valid & cmd.cmd_ready;
    acc_run  = accept & (cmd.cmd_op == OP_RUN);
    acc_halt = accept & (cmd.cmd_op == OP_HALT);
    acc_step = accept & (cmd.cmd_op == OP_STEP);
    active   = (state_q == S_RUNNING) | (state_q == S_STEPPING);
    // skip masks the match for the first enabled cycle after a resume, so
    // execution can leave a breakpoint PC without re-triggering on it.
    bp_match = bp_en & (pc_if == bp_addr) & ~skip_q;
    // A match blocks the enable in the same cycle, so the instruction at
    // bp_addr never reaches IF_ID.
    pipe_en  = active & ~bp_match;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    skip_d      = skip_q;
    bp_hit_d    = bp_hit;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if (pipe_en) begin
      skip_d = 1'b0;
    end
    if ((state_q == S_STEPPING) && pipe_en) begin
      remaining_d = remaining_q - 1'b1;
    end

    case (state_q)
      S_HALTED: begin
        if (acc_run) begin
          state_d  = S_RUNNING;
          skip_d   = 1'b1;
          bp_hit_d = 1'b0;
        end else if (acc_step) begin
          skip_d   = 1'b1;
          bp_hit_d = 1'b0;
          if (cmd.cmd_count == '0) begin
            // Zero-length step completes at once with no enabled cycle.
            done_d = 1'b1;
          end else begin
            state_d     = S_STEPPING;
            remaining_d = cmd.cmd_count;
          end
        end
      end

      S_RUNNING, S_STEPPING: begin
        // RUN/STEP while active is dropped; only the error pulse remains.
        err_d = acc_run | acc_step;
        if (bp_match) begin
          // Breakpoint wins over a simultaneous HALT so the host still
          // learns why the pipeline stopped.
          state_d     = S_HALTED;
          bp_hit_d    = 1'b1;
          done_d      = 1'b1;
          remaining_d = '0;
        end else if (acc_halt) begin
          // HALT on the final step cycle suppresses the completion pulse.
          state_d     = S_HALTED;
          remaining_d = '0;
        end else if ((state_q == S_STEPPING) && (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1})) begin
          state_d     = S_HALTED;
          done_d      = 1'b1;
          remaining_d = '0;
        end
      end

      default: begin
        state_d     = S_HALTED;
        remaining_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
      skip_q      <= 1'b0;
      bp_hit      <= 1'b0;
      done_pulse  <= 1'b0;
      cmd_err     <= 1'b0;
      cycle_count <= '0;
    end else begin
      remaining_q <= remaining_d;
      skip_q      <= skip_d;
      bp_hit      <= bp_hit_d;
      done_pulse  <= done_d;
      cmd_err     <= err_d;
      if (pipe_en) begin
        cycle_count <= cycle_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_run_control.sv
module tb_pipeline_run_control;

  localparam int CNT_W = 16;
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_STEP = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        pc_load;
  logic        pipe_en;
  logic [1:0]  state;
  logic        done_pulse;
  logic        bp_hit;
  logic        cmd_err;
  logic [31:0] cycle_count;

  pipeline_run_control_if #(.CNT_W(CNT_W)) cmd_bus ();

  pipeline_run_control #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd_bus.slave),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc_if       (pc),
    .pipe_en     (pipe_en),
    .state       (state),
    .done_pulse  (done_pulse),
    .bp_hit      (bp_hit),
    .cmd_err     (cmd_err),
    .cycle_count (cycle_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register gated by pipe_en, counting by 4
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 32'd0;
    else if (pc_load) pc <= 32'd0;
    else if (pipe_en) pc <= pc + 32'd4;
  end

  // ---------------- scoreboard ----------------
  // event = {cmd_err, done_pulse, bp_hit, state, cycle_count}
  logic [36:0] exp_q[$];
  int n_cmp;
  int n_fail;
  int en_cnt;

  function automatic logic [36:0] mk_ev(input logic err, input logic done,
                                        input logic bph, input logic [1:0] st,
                                        input logic [31:0] cc);
    return {err, done, bph, st, cc};
  endfunction

  always @(negedge clk) begin
    if (pipe_en) en_cnt++;
  end

  always @(negedge clk) begin
    logic [36:0] ev;
    logic [36:0] e;
    if (rst_n && (done_pulse || cmd_err)) begin
      ev = {cmd_err, done_pulse, bp_hit, state, cycle_count};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event actual=%h required=none", ev);
      end else begin
        e = exp_q.pop_front();
        if (ev !== e) begin
          n_fail++;
          $display("FAIL event actual=%h required=%h (err,done,bp,state,cc)", ev, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_count = cnt;
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = OP_NOP;
    cmd_bus.cmd_count = '0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout actual=%0d pending required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic reload_pc();
    @(negedge clk);
    pc_load = 1'b1;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int en0;
    n_cmp = 0;
    n_fail = 0;
    en_cnt = 0;
    rst_n = 1'b0;
    pc_load = 1'b0;
    bp_en = 1'b0;
    bp_addr = 32'd0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = OP_NOP;
    cmd_bus.cmd_count = '0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_pipe_en", {31'd0, pipe_en}, 32'd0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    chk("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
    chk("rst_done", {31'd0, done_pulse}, 32'd0);
    chk("rst_err", {31'd0, cmd_err}, 32'd0);
    chk("rst_ready", {31'd0, cmd_bus.cmd_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {31'd0, cmd_bus.cmd_ready}, 32'd1);

    // STEP 3
    en0 = en_cnt;
    exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b0, 2'b00, 32'd3));
    send_cmd(OP_STEP, 16'd3);
    drain("step3");
    chk("step3_en_cycles", en_cnt - en0, 32'd3);
    chk("step3_cycle_count", cycle_count, 32'd3);
    chk("step3_state", {30'd0, state}, 32'd0);

    // RUN into breakpoint at 0x10
    reload_pc();
    bp_en = 1'b1;
    bp_addr = 32'h10;
    en0 = en_cnt;
    exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b1, 2'b00, 32'd7));
    send_cmd(OP_RUN, 16'd0);
    drain("bp_run");
    chk("bp_en_cycles", en_cnt - en0, 32'd4);
    chk("bp_pc", pc, 32'h10);
    chk("bp_hit_set", {31'd0, bp_hit}, 32'd1);
    chk("bp_pipe_en", {31'd0, pipe_en}, 32'd0);

    // STEP 1 off the breakpoint
    en0 = en_cnt;
    exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b0, 2'b00, 32'd8));
    send_cmd(OP_STEP, 16'd1);
    drain("bp_step1");
    chk("bp_step1_en_cycles", en_cnt - en0, 32'd1);
    chk("bp_step1_pc", pc, 32'h14);
    chk("bp_step1_bp_hit", {31'd0, bp_hit}, 32'd0);
    bp_en = 1'b0;

    // RUN for 5 cycles, then HALT (no done pulse)
    en0 = en_cnt;
    send_cmd(OP_RUN, 16'd0);
    repeat (3) @(negedge clk);
    send_cmd(OP_HALT, 16'd0);
    #1;
    chk("halt_pipe_en", {31'd0, pipe_en}, 32'd0);
    chk("halt_state", {30'd0, state}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("halt_en_cycles", en_cnt - en0, 32'd5);
    chk("halt_cycle_count", cycle_count, 32'd13);

    // STEP 10 with a rejected STEP 2 in the middle
    en0 = en_cnt;
    exp_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 2'b10, 32'd15));
    exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b0, 2'b00, 32'd23));
    send_cmd(OP_STEP, 16'd10);
    send_cmd(OP_STEP, 16'd2);
    drain("step10");
    chk("step10_en_cycles", en_cnt - en0, 32'd10);

    // STEP 0: done with no enabled cycle
    en0 = en_cnt;
    exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b0, 2'b00, 32'd23));
    send_cmd(OP_STEP, 16'd0);
    drain("step0");
    repeat (2) @(negedge clk);
    #1;
    chk("step0_en_cycles", en_cnt - en0, 32'd0);
    chk("step0_state", {30'd0, state}, 32'd0);

    // STEP 2 with HALT on the last step cycle: no done pulse
    en0 = en_cnt;
    send_cmd(OP_STEP, 16'd2);
    send_cmd(OP_HALT, 16'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("halt_last_en_cycles", en_cnt - en0, 32'd2);
    chk("halt_last_state", {30'd0, state}, 32'd0);
    chk("halt_last_cycle_count", cycle_count, 32'd25);

    // HALT coinciding with a breakpoint match at 0x8
    reload_pc();
    bp_en = 1'b1;
    bp_addr = 32'h8;
    en0 = en_cnt;
    exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b1, 2'b00, 32'd27));
    send_cmd(OP_RUN, 16'd0);
    repeat (1) @(negedge clk);
    send_cmd(OP_HALT, 16'd0);
    drain("halt_bp");
    chk("halt_bp_en_cycles", en_cnt - en0, 32'd2);
    chk("halt_bp_pc", pc, 32'h8);
    bp_en = 1'b0;

    // Asynchronous reset in the middle of STEP 100
    send_cmd(OP_STEP, 16'd100);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pipe_en", {31'd0, pipe_en}, 32'd0);
    chk("mid_rst_state", {30'd0, state}, 32'd0);
    chk("mid_rst_cycle_count", cycle_count, 32'd0);
    chk("mid_rst_ready", {31'd0, cmd_bus.cmd_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en0 = en_cnt;
    repeat (10) @(negedge clk);
    #1;
    chk("post_rst_state", {30'd0, state}, 32'd0);
    chk("post_rst_en_cycles", en_cnt - en0, 32'd0);

    // NOP and HALT while halted are no-ops
    send_cmd(OP_NOP, 16'd5);
    send_cmd(OP_HALT, 16'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("noop_state", {30'd0, state}, 32'd0);
    chk("noop_cycle_count", cycle_count, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
